// File: rtl/cordic_pkg.sv
// Shared types and constants for the cordic phase generator and its dither LFSR.
package cordic_pkg;

    localparam int unsigned ANGLE_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StSweep = 2'd2
    } state_e;

    // Full scale 2^32 = 360 degrees
    localparam logic [ANGLE_WIDTH-1:0] ANGLE_0   = 32'h0000_0000;
    localparam logic [ANGLE_WIDTH-1:0] ANGLE_90  = 32'h4000_0000;
    localparam logic [ANGLE_WIDTH-1:0] ANGLE_180 = 32'h8000_0000;
    localparam logic [ANGLE_WIDTH-1:0] ANGLE_270 = 32'hC000_0000;

    localparam int unsigned LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/cordic_phase_lfsr.sv
// 16-bit maximal Fibonacci LFSR providing the low-order angle dither bits.
module cordic_phase_lfsr
    import cordic_pkg::*;
#(
    parameter int unsigned DITHER_BITS = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   advance_i,
    output logic [DITHER_BITS-1:0] dither_o
);

    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [LFSR_WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance_i) begin
            lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dither_o = lfsr_q[DITHER_BITS-1:0];

endmodule

// File: rtl/cordic_phase_gen.sv
// NCO phase front end: constant or linear-chirp angle stream for the cordic rotator.
// Optional angle dither enabled by defining CORDIC_PHASE_DITHER_EN.
module cordic_phase_gen
    import cordic_pkg::*;
#(
    parameter int unsigned DWELL_WIDTH = 16,
    parameter int unsigned DITHER_BITS = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   halt_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic                   cfg_mode_i,
    input  logic [ANGLE_WIDTH-1:0] cfg_ftw_i,
    input  logic [ANGLE_WIDTH-1:0] cfg_offset_i,
    input  logic [ANGLE_WIDTH-1:0] cfg_step_i,
    input  logic [ANGLE_WIDTH-1:0] cfg_stop_i,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell_i,
    output logic [ANGLE_WIDTH-1:0] angle_o,
    output logic                   angle_valid_o,
    output logic                   sweep_done_o,
    output logic                   busy_o
);

    state_e                 state_q, state_d;
    logic [ANGLE_WIDTH-1:0] acc_q, acc_d;
    logic [ANGLE_WIDTH-1:0] ftw_q, ftw_d;
    logic [ANGLE_WIDTH-1:0] offset_q, offset_d;
    logic [ANGLE_WIDTH-1:0] step_q, step_d;
    logic [ANGLE_WIDTH-1:0] stop_q, stop_d;
    logic [DWELL_WIDTH-1:0] dwell_cfg_q, dwell_cfg_d;
    logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
    logic                   angle_valid_q, angle_valid_d;
    logic                   sweep_done_q, sweep_done_d;

    logic                   advance;
    logic                   accept;
    logic [ANGLE_WIDTH:0]   ftw_next_wide;
    logic [ANGLE_WIDTH-1:0] dither;

    assign cfg_ready_o   = ~rst_i;
    assign advance       = enable_i && (state_q != StIdle);
    assign accept        = cfg_valid_i && cfg_ready_o && !halt_i;
    assign ftw_next_wide = {1'b0, ftw_q} + {1'b0, step_q};

`ifdef CORDIC_PHASE_DITHER_EN
    logic [DITHER_BITS-1:0] dither_bits;

    cordic_phase_lfsr #(
        .DITHER_BITS (DITHER_BITS)
    ) u_lfsr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .advance_i (advance && !halt_i),
        .dither_o  (dither_bits)
    );

    assign dither = ANGLE_WIDTH'(dither_bits);
`else
    assign dither = ANGLE_0;
`endif

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        ftw_d         = ftw_q;
        offset_d      = offset_q;
        step_d        = step_q;
        stop_d        = stop_q;
        dwell_cfg_d   = dwell_cfg_q;
        dwell_cnt_d   = dwell_cnt_q;
        angle_d       = angle_q;
        angle_valid_d = 1'b0;
        sweep_done_d  = 1'b0;

        if (halt_i) begin
            state_d = StIdle;
            acc_d   = ANGLE_0;
            angle_d = ANGLE_0;
        end else begin
            if (advance) begin
                angle_d       = acc_q + offset_q + dither;
                acc_d         = acc_q + ftw_q;
                angle_valid_d = 1'b1;
                if (state_q == StSweep) begin
                    if (dwell_cnt_q == '0) begin
                        dwell_cnt_d = dwell_cfg_q;
                        if (ftw_next_wide >= {1'b0, stop_q}) begin
                            ftw_d        = stop_q;
                            sweep_done_d = 1'b1;
                            state_d      = StRun;
                        end else begin
                            ftw_d = ftw_next_wide[ANGLE_WIDTH-1:0];
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - 1'b1;
                    end
                end
            end

            // A new config overrides any sweep bookkeeping from this same edge
            if (accept) begin
                ftw_d       = cfg_ftw_i;
                offset_d    = cfg_offset_i;
                step_d      = cfg_step_i;
                stop_d      = cfg_stop_i;
                dwell_cfg_d = cfg_dwell_i;
                dwell_cnt_d = cfg_dwell_i;
                if (state_q == StIdle) begin
                    acc_d = ANGLE_0;
                end
                if (!cfg_mode_i || (cfg_step_i == '0)) begin
                    state_d = StRun;
                end else if (cfg_ftw_i >= cfg_stop_i) begin
                    state_d      = StRun;
                    sweep_done_d = 1'b1;
                end else begin
                    state_d = StSweep;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            acc_q         <= ANGLE_0;
            ftw_q         <= '0;
            offset_q      <= '0;
            step_q        <= '0;
            stop_q        <= '0;
            dwell_cfg_q   <= '0;
            dwell_cnt_q   <= '0;
            angle_q       <= ANGLE_0;
            angle_valid_q <= 1'b0;
            sweep_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            ftw_q         <= ftw_d;
            offset_q      <= offset_d;
            step_q        <= step_d;
            stop_q        <= stop_d;
            dwell_cfg_q   <= dwell_cfg_d;
            dwell_cnt_q   <= dwell_cnt_d;
            angle_q       <= angle_d;
            angle_valid_q <= angle_valid_d;
            sweep_done_q  <= sweep_done_d;
        end
    end

    assign angle_o       = angle_q;
    assign angle_valid_o = angle_valid_q;
    assign sweep_done_o  = sweep_done_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed self-checking bench for cordic_phase_gen (default build, no dither).
module tb_cordic_phase_gen;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        halt;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_mode;
    logic [31:0] cfg_ftw;
    logic [31:0] cfg_offset;
    logic [31:0] cfg_step;
    logic [31:0] cfg_stop;
    logic [15:0] cfg_dwell;
    logic [31:0] angle;
    logic        angle_valid;
    logic        sweep_done;
    logic        busy;

    int unsigned n_checks;
    int unsigned n_pass;

    cordic_phase_gen dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .halt_i        (halt),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cfg_mode_i    (cfg_mode),
        .cfg_ftw_i     (cfg_ftw),
        .cfg_offset_i  (cfg_offset),
        .cfg_step_i    (cfg_step),
        .cfg_stop_i    (cfg_stop),
        .cfg_dwell_i   (cfg_dwell),
        .angle_o       (angle),
        .angle_valid_o (angle_valid),
        .sweep_done_o  (sweep_done),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples live 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic mode, input logic [31:0] ftw, input logic [31:0] off,
                            input logic [31:0] stp, input logic [31:0] stop,
                            input logic [15:0] dwell);
        cfg_valid  = 1'b1;
        cfg_mode   = mode;
        cfg_ftw    = ftw;
        cfg_offset = off;
        cfg_step   = stp;
        cfg_stop   = stop;
        cfg_dwell  = dwell;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_halt();
        halt = 1'b1;
        tick();
        halt = 1'b0;
    endtask

    logic [31:0] sweep_exp [10];
    logic [31:0] exp_a;
    int unsigned done_cnt;

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        enable     = 1'b0;
        halt       = 1'b0;
        cfg_valid  = 1'b0;
        cfg_mode   = 1'b0;
        cfg_ftw    = '0;
        cfg_offset = '0;
        cfg_step   = '0;
        cfg_stop   = '0;
        cfg_dwell  = '0;
        sweep_exp  = '{32'h0, 32'h100, 32'h200, 32'h400, 32'h600,
                       32'h900, 32'hC00, 32'h1000, 32'h1400, 32'h1800};

        // Reset state
        tick();
        tick();
        check_eq("rst_angle", angle, 32'h0);
        check_eq("rst_valid", {31'b0, angle_valid}, 32'h0);
        check_eq("rst_busy", {31'b0, busy}, 32'h0);
        check_eq("rst_done", {31'b0, sweep_done}, 32'h0);
        rst = 1'b0;
        tick();
        check_eq("ready_after_rst", {31'b0, cfg_ready}, 32'h1);

        // Quadrant wrap
        enable = 1'b1;
        load_cfg(1'b0, 32'h4000_0000, 32'h0, 32'h0, 32'h0, 16'h0);
        check_eq("quad_busy", {31'b0, busy}, 32'h1);
        check_eq("quad_accept_valid", {31'b0, angle_valid}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_a = (i == 4) ? 32'h0 : 32'h4000_0000 * i;
            check_eq($sformatf("quad_angle%0d", i), angle, exp_a);
            check_eq($sformatf("quad_valid%0d", i), {31'b0, angle_valid}, 32'h1);
        end

        // Enable gap: hold, then resume without skipping
        enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_eq("gap_angle_hold", angle, 32'h0);
        check_eq("gap_valid_low", {31'b0, angle_valid}, 32'h0);
        enable = 1'b1;
        tick();
        check_eq("gap_resume0", angle, 32'h4000_0000);
        check_eq("gap_resume_valid", {31'b0, angle_valid}, 32'h1);
        tick();
        check_eq("gap_resume1", angle, 32'h8000_0000);
        do_halt();
        check_eq("halt_busy", {31'b0, busy}, 32'h0);
        check_eq("halt_angle", angle, 32'h0);

        // One-degree stepping: sample 360 exposes acc after 360 accumulations
        load_cfg(1'b0, 32'h00B6_0B60, 32'h0, 32'h0, 32'h0, 16'h0);
        for (int n = 0; n <= 360; n++) begin
            tick();
            if (n == 1) check_eq("deg_s1", angle, 32'h00B6_0B60);
            if (n == 90) check_eq("deg_s90", angle, 32'h3FFF_FFC0);
            if (n == 359) check_eq("deg_s359", angle, 32'h00B6_0B60 * 359);
            if (n == 360) check_eq("deg_acc360", angle, 32'hFFFF_FF00);
        end
        do_halt();

        // Pure offset
        load_cfg(1'b0, 32'h0, 32'h2000_0000, 32'h0, 32'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("offset%0d", i), angle, 32'h2000_0000);
        end
        do_halt();

        // Linear sweep with dwell 1
        done_cnt = 0;
        load_cfg(1'b1, 32'h100, 32'h0, 32'h100, 32'h400, 16'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq($sformatf("sweep_angle%0d", k), angle, sweep_exp[k]);
            check_eq($sformatf("sweep_done%0d", k), {31'b0, sweep_done}, (k == 5) ? 32'h1 : 32'h0);
            if (sweep_done) done_cnt++;
        end
        check_eq("sweep_done_count", done_cnt, 32'd1);
        check_eq("sweep_end_busy", {31'b0, busy}, 32'h1);
        do_halt();

        // Sweep start already at/above stop: RUN with immediate done pulse
        load_cfg(1'b1, 32'h500, 32'h0, 32'h10, 32'h400, 16'd0);
        check_eq("sat_done", {31'b0, sweep_done}, 32'h1);
        tick();
        check_eq("sat_done_clear", {31'b0, sweep_done}, 32'h0);
        tick();
        check_eq("sat_ftw", angle, 32'h500);
        do_halt();

        // Asynchronous reset mid-sweep
        load_cfg(1'b1, 32'h100, 32'h0, 32'h100, 32'h10000, 16'd3);
        tick();
        tick();
        tick();
        check_eq("pre_rst_angle", angle, 32'h200);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_angle", angle, 32'h0);
        check_eq("arst_valid", {31'b0, angle_valid}, 32'h0);
        check_eq("arst_busy", {31'b0, busy}, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Halt wins over a simultaneous config
        load_cfg(1'b1, 32'h100, 32'h0, 32'h100, 32'h10000, 16'd0);
        tick();
        tick();
        check_eq("pre_halt_angle", angle, 32'h100);
        halt       = 1'b1;
        cfg_valid  = 1'b1;
        cfg_mode   = 1'b0;
        cfg_ftw    = 32'h1234;
        tick();
        halt      = 1'b0;
        cfg_valid = 1'b0;
        check_eq("hc_busy", {31'b0, busy}, 32'h0);
        check_eq("hc_angle", angle, 32'h0);
        check_eq("hc_valid", {31'b0, angle_valid}, 32'h0);
        tick();
        check_eq("hc_ignored_busy", {31'b0, busy}, 32'h0);
        check_eq("hc_ignored_valid", {31'b0, angle_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
